// File: rtl/fp_cmd_pkg.sv
// rtl/fp_cmd_pkg.sv - opcode, state and status-bit definitions for the command sequencer
`timescale 1ns/1ps
package fp_cmd_pkg;

  typedef enum logic [3:0] {
    OP_NOP     = 4'h0,
    OP_ADD     = 4'h1,
    OP_SUB     = 4'h2,
    OP_ACC     = 4'h3,
    OP_MUL     = 4'h4,
    OP_CLRACC  = 4'h5,
    OP_CLRSTAT = 4'hF
  } opcode_e;

  typedef enum logic {
    S_IDLE,
    S_EXEC
  } state_e;

  localparam int ST_BUSY    = 0;
  localparam int ST_ILLEGAL = 1;
  localparam int ST_OVERRUN = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_OP_LSB  = 12;
  localparam int ST_CNT_LSB = 16;

endpackage

// File: rtl/fp_shift_mul.sv
// rtl/fp_shift_mul.sv - iterative shift-add multiplier, one partial product per cycle
`timescale 1ns/1ps
module fp_shift_mul #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int IW = $clog2(W);

  logic [2*W-1:0] mcand_q;
  logic [W-1:0]   mplier_q;
  logic [2*W-1:0] prod_q;
  logic [IW-1:0]  iter_q;
  logic           busy_q;
  logic [2*W-1:0] partial;

  // product includes the current iteration, so it is complete in the same cycle done is high
  assign partial = mplier_q[0] ? mcand_q : '0;
  assign product = prod_q + partial;
  assign done    = busy_q && (iter_q == IW'(W - 1));
  assign busy    = busy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      iter_q   <= '0;
      busy_q   <= 1'b0;
    end else if (start) begin
      mcand_q  <= {{W{1'b0}}, a};
      mplier_q <= b;
      prod_q   <= '0;
      iter_q   <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      prod_q   <= product;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      iter_q   <= iter_q + 1'b1;
      if (done) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fp_cmd_sequencer.sv
// rtl/fp_cmd_sequencer.sv - toggle-launched command sequencer with ALU, accumulator and status
`timescale 1ns/1ps
module fp_cmd_sequencer
  import fp_cmd_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int MUL_CYCLES = 32
) (
  input  logic        okClk,
  input  logic        reset,
  input  logic [31:0] cmd_in,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic [31:0] result_out,
  output logic [31:0] status_out,
  output logic        done_pulse,
  output logic        busy
);

  state_e            state_q, state_d;
  logic              go_prev_q;
  logic [3:0]        op_q, op_d;
  logic [31:0]       a_q, a_d, b_q, b_d;
  logic [31:0]       acc_q, acc_d;
  logic [31:0]       result_q, result_d;
  logic [31:0]       status_q, status_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d, ovr_q, ovr_d, ill_q, ill_d;
  logic              done_q, done_d;
  logic              toggle, complete, mul_start, mul_done;
  logic [63:0]       mul_product;
  logic              unused_mul_busy;
  logic              unused_cmd;

  assign unused_cmd = ^cmd_in[30:4];
  assign toggle     = (cmd_in[31] != go_prev_q);

  fp_shift_mul #(.W(MUL_CYCLES)) u_mul (
    .clk     (okClk),
    .reset   (reset),
    .start   (mul_start),
    .a       (a_d),
    .b       (b_d),
    .busy    (unused_mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    ovr_d     = ovr_q;
    ill_d     = ill_q;
    done_d    = 1'b0;
    mul_start = 1'b0;
    complete  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (toggle) begin
          op_d      = cmd_in[3:0];
          a_d       = a_in;
          b_d       = b_in;
          state_d   = S_EXEC;
          mul_start = (cmd_in[3:0] == OP_MUL);
        end
      end
      S_EXEC: begin
        if (op_q == OP_MUL) begin
          if (mul_done) begin
            complete = 1'b1;
            result_d = mul_product[31:0];
            if (|mul_product[63:32]) ovf_d = 1'b1;
          end
        end else begin
          complete = 1'b1;
          case (op_q)
            OP_NOP:     begin end
            OP_ADD:     result_d = a_q + b_q;
            OP_SUB:     result_d = a_q - b_q;
            OP_ACC:     begin acc_d = acc_q + a_q; result_d = acc_d; end
            OP_CLRACC:  begin acc_d = '0; result_d = '0; end
            OP_CLRSTAT: begin ovf_d = 1'b0; ovr_d = 1'b0; ill_d = 1'b0; end
            default:    ill_d = 1'b1;
          endcase
        end
        // a toggle while executing (even on the completion edge) is dropped, never queued
        if (toggle) ovr_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (complete) begin
      cnt_d   = cnt_q + 1'b1;
      done_d  = 1'b1;
      state_d = S_IDLE;
    end
    status_d                        = '0;
    status_d[ST_CNT_LSB +: 16]      = 16'(cnt_q);
    status_d[ST_OP_LSB +: 4]        = op_q;
    status_d[ST_OVF]                = ovf_q;
    status_d[ST_OVERRUN]            = ovr_q;
    status_d[ST_ILLEGAL]            = ill_q;
    status_d[ST_BUSY]               = (state_q == S_EXEC);
  end

  always_ff @(posedge okClk) begin
    go_prev_q <= cmd_in[31];
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      status_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      ovr_q    <= 1'b0;
      ill_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      status_q <= status_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      ovr_q    <= ovr_d;
      ill_q    <= ill_d;
      done_q   <= done_d;
    end
  end

  assign result_out = result_q;
  assign status_out = status_q;
  assign done_pulse = done_q;
  assign busy       = (state_q == S_EXEC);

endmodule

// File: tb/tb_fp_cmd_sequencer.sv
// tb/tb_fp_cmd_sequencer.sv - directed self-checking bench for fp_cmd_sequencer
`timescale 1ns/1ps
module tb_fp_cmd_sequencer;

  logic        okClk;
  logic        reset;
  logic [31:0] cmd_in;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [31:0] result_out;
  logic [31:0] status_out;
  logic        done_pulse;
  logic        busy;

  int errors;
  int checks;

  fp_cmd_sequencer #(.CNT_W(16), .MUL_CYCLES(32)) dut (
    .okClk      (okClk),
    .reset      (reset),
    .cmd_in     (cmd_in),
    .a_in       (a_in),
    .b_in       (b_in),
    .result_out (result_out),
    .status_out (status_out),
    .done_pulse (done_pulse),
    .busy       (busy)
  );

  initial okClk = 1'b0;
  always #5 okClk = ~okClk;

  task automatic run_cmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int bcyc, output int dones);
    bcyc  = 0;
    dones = 0;
    a_in   = a;
    b_in   = b;
    cmd_in = {~cmd_in[31], 27'd0, op};
    for (int i = 0; i < 100; i++) begin
      @(posedge okClk); #1;
      if (busy) bcyc++;
      if (done_pulse) begin
        dones++;
        break;
      end
    end
    @(posedge okClk); #1;
    if (done_pulse) dones++;
    if (busy) bcyc++;
  endtask

  task automatic test_reset;
    reset  = 1'b1;
    cmd_in = 32'h8000_0000;
    a_in   = 32'h0;
    b_in   = 32'h0;
    repeat (3) @(posedge okClk);
    #1 reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge okClk); #1;
      checks++;
      if (result_out !== 32'h0) begin errors++; $display("FAIL reset_result cyc%0d got %h exp 0", i, result_out); end
      checks++;
      if (status_out !== 32'h0) begin errors++; $display("FAIL reset_status cyc%0d got %h exp 0", i, status_out); end
      checks++;
      if (busy !== 1'b0 || done_pulse !== 1'b0) begin
        errors++; $display("FAIL reset_busy_done cyc%0d got %b%b exp 00", i, busy, done_pulse);
      end
    end
  endtask

  task automatic test_add;
    int bc, dn;
    run_cmd(4'h1, 32'hFFFF_FFFF, 32'h2, bc, dn);
    checks++; if (bc !== 1) begin errors++; $display("FAIL add_busy got %0d exp 1", bc); end
    checks++; if (dn !== 1) begin errors++; $display("FAIL add_done got %0d exp 1", dn); end
    checks++; if (result_out !== 32'h1) begin errors++; $display("FAIL add_result got %h exp 1", result_out); end
    checks++; if (status_out !== 32'h0001_1000) begin errors++; $display("FAIL add_status got %h exp 00011000", status_out); end
  endtask

  task automatic test_mul;
    int bc, dn;
    run_cmd(4'h4, 32'h0001_0000, 32'h0001_0000, bc, dn);
    checks++; if (bc !== 32) begin errors++; $display("FAIL mul_ovf_busy got %0d exp 32", bc); end
    checks++; if (dn !== 1) begin errors++; $display("FAIL mul_ovf_done got %0d exp 1", dn); end
    checks++; if (result_out !== 32'h0) begin errors++; $display("FAIL mul_ovf_result got %h exp 0", result_out); end
    checks++; if (status_out !== 32'h0002_4008) begin errors++; $display("FAIL mul_ovf_status got %h exp 00024008", status_out); end
    run_cmd(4'h4, 32'd1234, 32'd5678, bc, dn);
    checks++; if (bc !== 32) begin errors++; $display("FAIL mul_busy got %0d exp 32", bc); end
    checks++; if (result_out !== 32'd7006652) begin errors++; $display("FAIL mul_result got %0d exp 7006652", result_out); end
    checks++; if (status_out !== 32'h0003_4008) begin errors++; $display("FAIL mul_status got %h exp 00034008", status_out); end
    run_cmd(4'hF, 32'h0, 32'h0, bc, dn);
    checks++; if (status_out !== 32'h0004_F000) begin errors++; $display("FAIL clrstat_status got %h exp 0004F000", status_out); end
    checks++; if (result_out !== 32'd7006652) begin errors++; $display("FAIL clrstat_result got %0d exp 7006652", result_out); end
  endtask

  task automatic test_acc;
    int bc, dn;
    for (int k = 1; k <= 3; k++) begin
      run_cmd(4'h3, 32'd10, 32'd99, bc, dn);
      checks++;
      if (result_out !== 32'(10 * k)) begin errors++; $display("FAIL acc_result%0d got %0d exp %0d", k, result_out, 10 * k); end
    end
    run_cmd(4'h5, 32'd77, 32'd0, bc, dn);
    checks++; if (result_out !== 32'h0) begin errors++; $display("FAIL clracc_result got %0d exp 0", result_out); end
    checks++; if (status_out !== 32'h0008_5000) begin errors++; $display("FAIL clracc_status got %h exp 00085000", status_out); end
  endtask

  task automatic test_overrun;
    int bc, dn;
    bc = 0;
    dn = 0;
    a_in   = 32'h1234;
    b_in   = 32'h5678;
    cmd_in = {~cmd_in[31], 27'd0, 4'h4};
    @(posedge okClk); #1;
    if (busy) bc++;
    a_in = 32'hDEAD_BEEF;
    b_in = 32'h1111_1111;
    repeat (10) begin @(posedge okClk); #1; if (busy) bc++; end
    cmd_in = {~cmd_in[31], 27'd0, 4'h1};
    for (int i = 0; i < 60; i++) begin
      @(posedge okClk); #1;
      if (busy) bc++;
      if (done_pulse) dn++;
    end
    checks++; if (bc !== 32) begin errors++; $display("FAIL ovr_busy got %0d exp 32", bc); end
    checks++; if (dn !== 1) begin errors++; $display("FAIL ovr_done got %0d exp 1", dn); end
    checks++; if (result_out !== 32'd103153760) begin errors++; $display("FAIL ovr_result got %0d exp 103153760", result_out); end
    checks++; if (status_out !== 32'h0009_4004) begin errors++; $display("FAIL ovr_status got %h exp 00094004", status_out); end
  endtask

  task automatic test_illegal;
    int bc, dn;
    run_cmd(4'h9, 32'h5, 32'h6, bc, dn);
    checks++; if (bc !== 1 || dn !== 1) begin errors++; $display("FAIL ill_handshake got busy %0d done %0d exp 1 1", bc, dn); end
    checks++; if (result_out !== 32'd103153760) begin errors++; $display("FAIL ill_result got %0d exp 103153760", result_out); end
    checks++; if (status_out !== 32'h000A_9006) begin errors++; $display("FAIL ill_status got %h exp 000A9006", status_out); end
  endtask

  task automatic test_back_to_back;
    int bc, dn;
    run_cmd(4'hF, 32'h0, 32'h0, bc, dn);
    a_in   = 32'd3;
    b_in   = 32'd4;
    cmd_in = {~cmd_in[31], 27'd0, 4'h1};
    @(posedge okClk); #1;
    cmd_in = {~cmd_in[31], 27'd0, 4'h2};
    bc = 0;
    dn = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge okClk); #1;
      if (busy) bc++;
      if (done_pulse) dn++;
    end
    checks++; if (bc !== 0 || dn !== 1) begin errors++; $display("FAIL b2b_handshake got busy %0d done %0d exp 0 1", bc, dn); end
    checks++; if (result_out !== 32'd7) begin errors++; $display("FAIL b2b_result got %0d exp 7", result_out); end
    checks++; if (status_out !== 32'h000C_1004) begin errors++; $display("FAIL b2b_status got %h exp 000C1004", status_out); end
  endtask

  task automatic test_reset_mid_mul;
    int dn;
    dn = 0;
    a_in   = 32'h0001_0000;
    b_in   = 32'h0001_0000;
    cmd_in = {~cmd_in[31], 27'd0, 4'h4};
    repeat (21) begin @(posedge okClk); #1; if (done_pulse) dn++; end
    reset = 1'b1;
    @(posedge okClk); #1;
    checks++; if (result_out !== 32'h0 || status_out !== 32'h0) begin
      errors++; $display("FAIL rstmul_outputs got %h %h exp 0 0", result_out, status_out);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmul_busy got %b exp 0", busy); end
    @(posedge okClk); #1 reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge okClk); #1;
      if (done_pulse) dn++;
    end
    checks++; if (dn !== 0) begin errors++; $display("FAIL rstmul_done got %0d exp 0", dn); end
    checks++; if (result_out !== 32'h0 || status_out !== 32'h0 || busy !== 1'b0) begin
      errors++; $display("FAIL rstmul_after got %h %h %b exp 0 0 0", result_out, status_out, busy);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_add();
    test_mul();
    test_acc();
    test_overrun();
    test_illegal();
    test_back_to_back();
    test_reset_mid_mul();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
